cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits directly downstream of the L1 instruction and data caches that serve the CPU datapath's instruction and data ports.
- Merges their line-fill and write-back traffic onto the single unified L2 port.
- Arbitration is alternating-priority with a registered request capture.
- Includes a saturating contention counter that is readable by the MMIO counter block.

Parameters:
ADDR_W, 16, byte address width.
LINE_W, 128, cache line width in bits; LINE_W/8 must be a power of two.
CNT_W, 16, contention counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
i_req  in  1  I-cache line read request; held until i_resp.
i_addr  in  ADDR_W  I-cache request address.
i_rdata  out  LINE_W  line returned to I-cache.
i_resp  out  1  one-cycle completion pulse to I-cache.
d_req  in  1  D-cache request; held until d_resp.
d_we  in  1  1 = line write-back, 0 = line read.
d_addr  in  ADDR_W  D-cache request address.
d_wdata  in  LINE_W  write-back line.
d_rdata  out  LINE_W  line returned to D-cache.
d_resp  out  1  one-cycle completion pulse to D-cache.
l2_req  out  1  request to L2.
l2_we  out  1  write strobe to L2.
l2_addr  out  ADDR_W  line-aligned address to L2.
l2_wdata  out  LINE_W  write line to L2.
l2_rdata  in  LINE_W  read line from L2.
l2_resp  in  1  L2 completion pulse.
stall_count_clear  in  1  synchronous clear of stall_count.
stall_count  out  CNT_W  contention cycle count.

Behaviour:
- Reset values:
  - state = IDLE; last_grant = I, so D wins the first tie.
  - Latched address, we and wdata = 0; stall_count = 0.
  - All outputs 0 while reset is asserted, effective immediately (asynchronous).
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Both requests pending: grant the side not equal to last_grant.
  - Only one pending: grant it.
  - Neither pending: stay in IDLE.
  - On grant, at the clock edge: latch address with its low log2(LINE_W/8) bits forced to 0; latch d_we and d_wdata (we forced 0 for I); update last_grant; move to SERVE_x.
  - l2_req = 0 throughout IDLE.
  - Grant-to-l2_req latency is 1 cycle.
- SERVE_x:
  - l2_req = 1; l2_addr, l2_we and l2_wdata driven from the latched registers, stable for the whole transaction.
  - In SERVE_I, l2_we = 0.
  - On l2_resp = 1: x_resp = 1 combinationally in the same cycle and x_rdata = l2_rdata; next state IDLE.
  - x_rdata is also driven from l2_rdata in other cycles; consumers must qualify it with x_resp.
- Turnaround: one mandatory IDLE cycle between transactions. A requester drops req in the cycle after its resp, so it is not regranted.
- Requester drops req mid-service: the transaction still completes and x_resp still pulses. No abort.
- l2_resp while in IDLE: ignored, no x_resp.
- l2_resp in the same cycle as a new request arrives: the new request is serviced only after the IDLE turnaround.
- x_resp never asserts for the non-granted side.
- stall_count:
  - Increments by 1 on each cycle where state is SERVE_x and the other side's req = 1.
  - Also increments in an IDLE cycle with both reqs = 1 (the loser waits).
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_count_clear takes priority over increment: the value is 0 on the next cycle.
- Reset mid-transaction: l2_req drops immediately and the state returns to IDLE. An L2 response arriving after reset is ignored. Requesters must reissue.
- Throughput: single outstanding L2 transaction. Minimum transaction = 1 (grant) + L2 latency + 1 (turnaround) cycles.

Test Plan:
- I-only read: i_req=1, i_addr=16'h1236; L2 responds 3 cycles after l2_req with 128'hA5…A5 -> l2_addr=16'h1230, l2_we=0; i_resp pulses exactly 1 cycle with i_rdata=128'hA5…A5; d_resp stays 0.
- D write-back: d_req=1, d_we=1, d_addr=16'h2008, d_wdata=128'h0123…CDEF -> l2_we=1, l2_addr=16'h2000, l2_wdata is stable until l2_resp; d_resp pulses once.
- Simultaneous requests after reset -> D served first, then I after the IDLE turnaround. stall_count=1 (IDLE tie) + the D L2 latency cycles; with a 2-cycle L2 it reads 3 after the D grant completes.
- Repeated contention (both held continuously, 4 transactions) -> grant order D, I, D, I; no back-to-back grants to the same side.
- Reset asserted while in SERVE_D with l2_req=1 -> l2_req=0 in the same cycle; a later l2_resp produces no d_resp; state is IDLE.
- Counter: force 2^16+5 contention cycles -> stall_count holds 16'hFFFF. Assert stall_count_clear concurrently with contention -> stall_count=0 on the next cycle.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: L1 I/D cache request buses and the unified L2 port seen by the arbiter
interface cache_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_req;
    logic              l2_we;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    // master: the arbiter, which masters the L2 port and answers the caches
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp, l2_req, l2_we, l2_addr, l2_wdata
    );
    // slave: the caches and L2 around the arbiter
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, l2_req, l2_we, l2_addr, l2_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: alternating-priority merge of I/D cache line traffic onto one L2 port
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    cache_arbiter_if.master   bus,
    input  logic              stall_count_clear,
    output logic [CNT_W-1:0]  stall_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    logic [1:0]        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_i, grant_d, contend;

    // grant selection, request capture and saturating contention count
    always_comb begin
        grant_d  = bus.d_req && (!bus.i_req || !last_d_q);
        grant_i  = bus.i_req && !grant_d;
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        contend  = 1'b0;
        if (state_q == IDLE) begin
            contend = bus.i_req && bus.d_req;
            if (grant_i || grant_d) begin
                state_d  = grant_d ? SERVE_D : SERVE_I;
                last_d_d = grant_d;
                addr_d   = (grant_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
                we_d     = grant_d && bus.d_we;
                wdata_d  = bus.d_wdata;
            end
        end else begin
            contend = (state_q == SERVE_I) ? bus.d_req : bus.i_req;
            if (bus.l2_resp) state_d = IDLE;
        end
        cnt_d = stall_count_clear ? '0 : (contend && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // state and captured request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.l2_req   = state_q != IDLE;
    assign bus.l2_we    = we_q && state_q == SERVE_D;
    assign bus.l2_addr  = addr_q;
    assign bus.l2_wdata = wdata_q;
    assign bus.i_resp   = state_q == SERVE_I && bus.l2_resp;
    assign bus.d_resp   = state_q == SERVE_D && bus.l2_resp;
    assign bus.i_rdata  = reset ? '0 : bus.l2_rdata;
    assign bus.d_rdata  = reset ? '0 : bus.l2_rdata;
    assign stall_count  = cnt_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized and directed checks of cache_arbiter against a transaction-level model
module tb_cache_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam int CW = 16;
    localparam int LINE_BYTES = LW / 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clr = 1'b0;
    logic [CW-1:0] stall_count;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .stall_count_clear (clr),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: who owns the L2 port (0 nobody, 1 I-cache, 2 D-cache) and what it asked for
    int          srv;
    bit          last_was_d;
    logic [AW-1:0] m_addr;
    bit          m_we;
    logic [LW-1:0] m_wdata;
    int          m_cnt;
    int          lat_left;
    int          lat_mode;
    bit          auto_req, hold, spurious, i_done, d_done;
    int          ipulses, dpulses;
    int          order[$];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit contend;
        logic [AW-1:0] a;
        contend = (srv == 0) ? (bus.i_req && bus.d_req) : (srv == 1) ? bus.d_req : bus.i_req;
        if (clr) m_cnt = 0;
        else if (contend && m_cnt < CNT_MAX) m_cnt++;
        if (srv != 0) begin
            if (bus.l2_resp) srv = 0;
        end else if (bus.i_req || bus.d_req) begin
            srv = (bus.i_req && bus.d_req) ? (last_was_d ? 1 : 2) : (bus.d_req ? 2 : 1);
            last_was_d = (srv == 2);
            a = (srv == 2) ? bus.d_addr : bus.i_addr;
            m_addr = a - (a % LINE_BYTES);
            m_we = (srv == 2) && bus.d_we;
            m_wdata = bus.d_wdata;
            lat_left = (lat_mode == -1) ? int'($urandom_range(0, 3)) : (lat_mode == -2) ? (1 << 30) : lat_mode;
        end
    endtask

    task automatic drive();
        clr = auto_req && $urandom_range(0, 49) == 0;
        if (i_done) bus.i_req = 1'b0;
        else if (auto_req && srv == 1 && bus.i_req && $urandom_range(0, 15) == 0) bus.i_req = 1'b0;
        else if (!bus.i_req && (hold || (auto_req && $urandom_range(0, 2) == 0))) begin
            bus.i_req = 1'b1;
            bus.i_addr = 16'($urandom);
        end
        if (d_done) bus.d_req = 1'b0;
        else if (auto_req && srv == 2 && bus.d_req && $urandom_range(0, 15) == 0) bus.d_req = 1'b0;
        else if (!bus.d_req && (hold || (auto_req && $urandom_range(0, 2) == 0))) begin
            bus.d_req = 1'b1;
            bus.d_we = 1'($urandom);
            bus.d_addr = 16'($urandom);
            bus.d_wdata = {4{$urandom}};
        end
        if (srv != 0) begin
            bus.l2_resp = (lat_left == 0);
            lat_left--;
        end else bus.l2_resp = spurious && $urandom_range(0, 7) == 0;
        bus.l2_rdata = {4{$urandom}};
    endtask

    task automatic cycle();
        @(negedge clk);
        check("l2_req", bus.l2_req, srv != 0);
        if (srv != 0) begin
            check("l2_addr", bus.l2_addr, m_addr);
            check("l2_we", bus.l2_we, srv == 2 && m_we);
            if (srv == 2 && m_we) check("l2_wdata", bus.l2_wdata, m_wdata);
        end
        check("i_resp", bus.i_resp, srv == 1 && bus.l2_resp);
        check("d_resp", bus.d_resp, srv == 2 && bus.l2_resp);
        if (srv == 1 && bus.l2_resp) check("i_rdata", bus.i_rdata, bus.l2_rdata);
        if (srv == 2 && bus.l2_resp) check("d_rdata", bus.d_rdata, bus.l2_rdata);
        check("stall_count", stall_count, m_cnt);
        if (bus.i_resp) begin ipulses++; order.push_back(1); end
        if (bus.d_resp) begin dpulses++; order.push_back(2); end
        i_done = srv == 1 && bus.l2_resp;
        d_done = srv == 2 && bus.l2_resp;
        @(posedge clk);
        model_step();
        #1;
        drive();
    endtask

    task automatic wait_resp(input int side, input int budget);
        int start;
        start = (side == 1) ? ipulses : dpulses;
        for (int k = 0; k < budget && ((side == 1) ? ipulses : dpulses) == start; k++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.l2_resp = 1'b0;
        bus.l2_rdata = {4{$urandom}} | 128'h1;
        srv = 0; last_was_d = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_cnt = 0;
        i_done = 1'b0; d_done = 1'b0; ipulses = 0; dpulses = 0;
        order.delete();
        repeat (2) @(negedge clk);
        check("rst_l2_req", bus.l2_req, 1'b0);
        check("rst_l2_addr", bus.l2_addr, '0);
        check("rst_l2_wdata", bus.l2_wdata, '0);
        check("rst_i_rdata", bus.i_rdata, '0);
        check("rst_d_rdata", bus.d_rdata, '0);
        check("rst_stall_count", stall_count, '0);
        reset = 1'b0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        auto_req = 1'b0; hold = 1'b0; spurious = 1'b0; lat_mode = 0;
        do_reset();

        // I-only line read, L2 answering 3 cycles after l2_req
        lat_mode = 3;
        bus.i_req = 1'b1; bus.i_addr = 16'h1236;
        cycle();
        check("tp1_l2_addr", bus.l2_addr, 16'h1230);
        check("tp1_l2_we", bus.l2_we, 1'b0);
        wait_resp(1, 20);
        cycle();
        check("tp1_i_pulses", ipulses, 1);
        check("tp1_d_pulses", dpulses, 0);

        // D write-back
        lat_mode = 2;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h2008;
        bus.d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        cycle();
        check("tp2_l2_addr", bus.l2_addr, 16'h2000);
        check("tp2_l2_we", bus.l2_we, 1'b1);
        check("tp2_l2_wdata", bus.l2_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        wait_resp(2, 20);
        cycle();
        check("tp2_d_pulses", dpulses, 1);
        check("tp2_i_pulses", ipulses, 1);

        // simultaneous requests after reset: D first, tie plus two serve cycles counted
        do_reset();
        lat_mode = 1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0080;
        wait_resp(2, 20);
        check("tie_stall_count", stall_count, 3);
        wait_resp(1, 20);
        check("tie_first", order.size() > 0 ? order[0] : 0, 2);
        check("tie_second", order.size() > 1 ? order[1] : 0, 1);

        // continuous contention alternates grants
        do_reset();
        hold = 1'b1; lat_mode = -1;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wdata = {4{$urandom}};
        for (int k = 0; k < 200 && order.size() < 4; k++) cycle();
        for (int k = 0; k < 4; k++) check($sformatf("alt_%0d", k), order.size() > k ? order[k] : 0, (k % 2 == 0) ? 2 : 1);
        hold = 1'b0;

        // randomized traffic with spurious L2 responses and counter clears
        do_reset();
        auto_req = 1'b1; spurious = 1'b1; lat_mode = -1;
        repeat (3000) cycle();
        auto_req = 1'b0; spurious = 1'b0;

        // reset during a D transaction
        do_reset();
        lat_mode = -2;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h3456; bus.d_wdata = {4{$urandom}};
        cycle();
        cycle();
        check("mid_l2_req_before", bus.l2_req, 1'b1);
        bus.l2_resp = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_l2_req_async", bus.l2_req, 1'b0);
        check("mid_d_resp_async", bus.d_resp, 1'b0);
        do_reset();
        bus.l2_resp = 1'b1;
        cycle();
        check("mid_late_d_pulses", dpulses, 0);

        // saturation under permanent contention, then clear while still contending
        do_reset();
        lat_mode = -2;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
        repeat ((1 << CW) + 5) cycle();
        check("sat_stall_count", stall_count, 16'hFFFF);
        clr = 1'b1;
        cycle();
        check("clr_stall_count", stall_count, 16'h0000);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
